// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port between two requesters.
// Port 0 (data memory) and port 1 (secondary master) are served one
// transaction at a time; every transaction is followed by a one-cycle
// RELEASE with all memory enables low.
// Optional build macro: SRAM_ARB_ROUND_ROBIN_EN selects a last-served
// round-robin tie-break instead of fixed p0 priority.
module sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_read_en,
  input  logic              p0_write_en,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_write_data,
  output logic [DATA_W-1:0] p0_read_data,
  output logic              p0_ready,
  input  logic              p1_read_en,
  input  logic              p1_write_en,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_write_data,
  output logic [DATA_W-1:0] p1_read_data,
  output logic              p1_ready,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT0  = 2'd1,
    GRANT1  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              req0_s, req1_s;
  logic              done0_s, done1_s;
  logic              cap0_s, cap1_s;
  logic              pick1_s;

  assign req0_s = p0_read_en | p0_write_en;
  assign req1_s = p1_read_en | p1_write_en;

  // The owner's enables equal its request, so completion is mem_ready while
  // granted and still requesting.
  assign done0_s = (state_q == GRANT0) & mem_ready & req0_s;
  assign done1_s = (state_q == GRANT1) & mem_ready & req1_s;

  // A write wins over a simultaneous read, so only pure reads capture data.
  assign cap0_s = done0_s & p0_read_en & ~p0_write_en;
  assign cap1_s = done1_s & p1_read_en & ~p1_write_en;

  assign p0_ready = ~req0_s | done0_s;
  assign p1_ready = ~req1_s | done1_s;

  // Read data bypasses the controller in the completion cycle, else holds.
  assign p0_read_data = cap0_s ? mem_read_data : rdata0_q;
  assign p1_read_data = cap1_s ? mem_read_data : rdata1_q;
  assign rdata0_d     = cap0_s ? mem_read_data : rdata0_q;
  assign rdata1_d     = cap1_s ? mem_read_data : rdata1_q;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic prefer1_q, prefer1_d;

  // Last-served pointer: the port just completed loses the next tie.
  always_comb begin
    prefer1_d = prefer1_q;
    if (done0_s) begin
      prefer1_d = 1'b1;
    end else if (done1_s) begin
      prefer1_d = 1'b0;
    end else begin
      prefer1_d = prefer1_q;
    end
  end

  // Pointer register, p0 preferred out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prefer1_q <= 1'b0;
    end else begin
      prefer1_q <= prefer1_d;
    end
  end

  assign pick1_s = prefer1_q;
`else
  assign pick1_s = 1'b0;
`endif

  // Next-state logic plus pass-through of the granted port onto mem_*.
  always_comb begin
    state_d        = state_q;
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    mem_address    = {ADDR_W{1'b0}};
    mem_write_data = {DATA_W{1'b0}};
    grant          = 2'b00;
    busy           = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_s && req1_s) begin
          state_d = pick1_s ? GRANT1 : GRANT0;
        end else if (req0_s) begin
          state_d = GRANT0;
        end else if (req1_s) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        grant          = 2'b01;
        busy           = 1'b1;
        mem_write_en   = p0_write_en;
        mem_read_en    = p0_read_en & ~p0_write_en;
        mem_address    = p0_address;
        mem_write_data = p0_write_data;
        if (!req0_s || done0_s) begin
          state_d = RELEASE;
        end else begin
          state_d = GRANT0;
        end
      end
      GRANT1: begin
        grant          = 2'b10;
        busy           = 1'b1;
        mem_write_en   = p1_write_en;
        mem_read_en    = p1_read_en & ~p1_write_en;
        mem_address    = p1_address;
        mem_write_data = p1_write_data;
        if (!req1_s || done1_s) begin
          state_d = RELEASE;
        end else begin
          state_d = GRANT1;
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and per-port read-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      rdata0_q <= {DATA_W{1'b0}};
      rdata1_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: a 5-cycle SRAM controller model, a scoreboard of
// expected completions, a vector table and hand-written corner sequences.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
  logic [31:0] p0_address, p0_write_data, p0_read_data;
  logic [31:0] p1_address, p1_write_data, p1_read_data;
  logic        p0_ready, p1_ready;
  logic        mem_read_en, mem_write_en, mem_ready;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [1:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int comp0  = 0;
  int comp1  = 0;
  logic [31:0] last0, last1;

  typedef struct {
    int          port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_read_en(p0_read_en), .p0_write_en(p0_write_en),
    .p0_address(p0_address), .p0_write_data(p0_write_data),
    .p0_read_data(p0_read_data), .p0_ready(p0_ready),
    .p1_read_en(p1_read_en), .p1_write_en(p1_write_en),
    .p1_address(p1_address), .p1_write_data(p1_write_data),
    .p1_read_data(p1_read_data), .p1_ready(p1_ready),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .grant(grant), .busy(busy)
  );

  // Controller model: ready in the 5th cycle of a continuous enable.
  logic [31:0] sram [0:1023];
  logic [3:0]  cnt_q;

  function automatic logic [31:0] pat(input int idx);
    return 32'hC0DE0000 | 32'(idx);
  endfunction

  assign mem_ready     = (mem_read_en | mem_write_en) && (cnt_q == 4'd4);
  assign mem_read_data = sram[mem_address[11:2]];

  always @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 4'd0;
    else if ((mem_read_en | mem_write_en) && !mem_ready) cnt_q <= cnt_q + 4'd1;
    else cnt_q <= 4'd0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) sram[i] <= pat(i);
    end else if (mem_write_en && mem_ready) begin
      sram[mem_address[11:2]] <= mem_write_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input int port, input logic [31:0] rdata);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_unexpected_done", 32'(port), 32'hFFFFFFFF);
    end else begin
      e = sb.pop_front();
      chk("sb_port_order", 32'(port), 32'(e.port));
      if (e.is_read) chk("sb_read_data", rdata, e.data);
    end
  endtask

  // Drive one request on a port and hold it until that port's ready.
  task automatic do_req(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit got;
    if (port == 0) begin
      p0_write_en = we; p0_read_en = ~we; p0_address = addr; p0_write_data = wdata;
    end else begin
      p1_write_en = we; p1_read_en = ~we; p1_address = addr; p1_write_data = wdata;
    end
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (port == 0) got = p0_ready;
      else got = p1_ready;
    end
    chk("req_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (port == 0) begin
      p0_write_en = 1'b0; p0_read_en = 1'b0;
    end else begin
      p1_write_en = 1'b0; p1_read_en = 1'b0;
    end
  endtask

  task automatic wait_grant(input logic [1:0] g);
    int n;
    n = 0;
    while (grant !== g && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_grant", 32'(grant), 32'(g));
  endtask

  initial begin
    int n;
    int c0;
    vecs[0] = '{0, 1'b1, 32'h10, 32'h11112222, 32'h0};
    vecs[1] = '{1, 1'b1, 32'h14, 32'h33334444, 32'h0};
    vecs[2] = '{0, 1'b0, 32'h14, 32'h0,        32'h33334444};
    vecs[3] = '{1, 1'b0, 32'h10, 32'h0,        32'h11112222};
    vecs[4] = '{1, 1'b1, 32'h10, 32'hA5A5A5A5, 32'h0};
    vecs[5] = '{0, 1'b0, 32'h10, 32'h0,        32'hA5A5A5A5};
    vecs[6] = '{0, 1'b1, 32'h14, 32'h0,        32'h0};
    vecs[7] = '{1, 1'b0, 32'h14, 32'h0,        32'h0};

    rst = 1'b0;
    p0_read_en = 1'b0; p0_write_en = 1'b0; p0_address = 32'h0; p0_write_data = 32'h0;
    p1_read_en = 1'b0; p1_write_en = 1'b0; p1_address = 32'h0; p1_write_data = 32'h0;
    last0 = 32'h0; last1 = 32'h0;

    // Completion monitor feeding the scoreboard.
    fork
      forever begin
        @(negedge clk);
        if (rst && (p0_read_en | p0_write_en) && p0_ready) begin
          comp0++;
          sb_pop(0, p0_read_data);
        end
        if (rst && (p1_read_en | p1_write_en) && p1_ready) begin
          comp1++;
          sb_pop(1, p1_read_data);
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset then idle.
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_p0_ready", 32'(p0_ready), 32'd1);
    chk("rst_p1_ready", 32'(p1_ready), 32'd1);
    chk("rst_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_rd0", p0_read_data, 32'd0);
    chk("rst_rd1", p1_read_data, 32'd0);

    // Single write from p0.
    @(posedge clk); #1;
    sb.push_back('{0, 1'b0, 32'h0});
    c0 = comp0;
    p0_write_en = 1'b1; p0_address = 32'h400; p0_write_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_arb_grant", 32'(grant), 32'd0);
    chk("wr_arb_ready", 32'(p0_ready), 32'd0);
    @(negedge clk);
    chk("wr_grant", 32'(grant), 32'h1);
    chk("wr_busy", 32'(busy), 32'd1);
    chk("wr_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'h1);
    chk("wr_mem_addr", mem_address, 32'h400);
    chk("wr_mem_data", mem_write_data, 32'hDEADBEEF);
    n = 0;
    while (!p0_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_latency", 32'(n), 32'd4);
    @(posedge clk); #1;
    p0_write_en = 1'b0;
    @(negedge clk);
    chk("wr_release_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("wr_release_grant", 32'(grant), 32'd0);
    chk("wr_release_busy", 32'(busy), 32'd0);
    chk("wr_one_pulse", 32'(comp0 - c0), 32'd1);

    // Read after write on p1.
    @(posedge clk); #1;
    sb.push_back('{1, 1'b1, 32'hDEADBEEF});
    last1 = 32'hDEADBEEF;
    do_req(1, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    chk("raw_rd1_held", p1_read_data, 32'hDEADBEEF);
    chk("raw_rd0_same", p0_read_data, 32'h0);

    // Abort: p1 drops its read mid-GRANT1.
    @(posedge clk); #1;
    c0 = comp1;
    p1_read_en = 1'b1; p1_address = 32'h800;
    @(negedge clk);
    wait_grant(2'b10);
    @(posedge clk); #1;
    p1_read_en = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("abort_rd1_bypass", p1_read_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("abort_release_grant", 32'(grant), 32'd0);
    chk("abort_release_busy", 32'(busy), 32'd0);
    chk("abort_rd1_held", p1_read_data, 32'hDEADBEEF);
    chk("abort_no_pulse", 32'(comp1 - c0), 32'd0);

    // Vector table, one transaction at a time.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{vecs[i].port, ~vecs[i].we, vecs[i].rexp});
      if (!vecs[i].we) begin
        if (vecs[i].port == 0) last0 = vecs[i].rexp;
        else last1 = vecs[i].rexp;
      end
      do_req(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", i), p0_read_data, last0);
      chk($sformatf("vec%0d_rd1", i), p1_read_data, last1);
      @(posedge clk); #1;
    end

    // Reset asserted mid-GRANT0.
    p0_write_en = 1'b1; p0_address = 32'h20; p0_write_data = 32'h77;
    @(negedge clk);
    wait_grant(2'b01);
    #1 rst = 1'b0;
    #1;
    chk("mrst_mem_en", {30'd0, mem_read_en, mem_write_en}, 32'd0);
    chk("mrst_grant", 32'(grant), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_mem_addr", mem_address, 32'd0);
    chk("mrst_p0_ready", 32'(p0_ready), 32'd0);
    chk("mrst_rd0", p0_read_data, 32'd0);
    chk("mrst_rd1", p1_read_data, 32'd0);
    p0_write_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_idle_ready", 32'(p0_ready), 32'd1);

    // Repeated ties: both ports re-request right after each completion.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    sb.push_back('{0, 1'b1, pat(32'h40)});
    sb.push_back('{1, 1'b1, pat(32'h42)});
    sb.push_back('{0, 1'b1, pat(32'h41)});
    sb.push_back('{1, 1'b1, pat(32'h43)});
`else
    sb.push_back('{0, 1'b1, pat(32'h40)});
    sb.push_back('{0, 1'b1, pat(32'h41)});
    sb.push_back('{1, 1'b1, pat(32'h42)});
    sb.push_back('{1, 1'b1, pat(32'h43)});
`endif
    @(posedge clk); #1;
    fork
      begin
        do_req(0, 1'b0, 32'h100, 32'h0);
        do_req(0, 1'b0, 32'h104, 32'h0);
      end
      begin
        do_req(1, 1'b0, 32'h108, 32'h0);
        do_req(1, 1'b0, 32'h10C, 32'h0);
      end
    join

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_idle_grant", 32'(grant), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one SRAM controller port (32-bit word read/write, two-beat 16-bit SRAM access) between two requesters: port 0 (data memory / MEM stage) and port 1 (secondary master, e.g. fetch or write-back buffer).
- Sits between the requesters and the SRAM controller. It forwards one transaction at a time and returns a per-port ready that uses the controller's convention: ready is high when idle, and low while the port's request is pending.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- p0_read_en, p0_write_en  in  1 each  port 0 request strobes
- p0_address  in  ADDR_W  port 0 byte address
- p0_write_data  in  DATA_W  port 0 write word
- p0_read_data  out  DATA_W  port 0 read word
- p0_ready  out  1  port 0 ready / done
- p1_read_en, p1_write_en, p1_address, p1_write_data, p1_read_data, p1_ready  same as port 0, for port 1
- mem_read_en, mem_write_en  out  1 each  to SRAM controller
- mem_address  out  ADDR_W  to SRAM controller
- mem_write_data  out  DATA_W  to SRAM controller
- mem_read_data  in  DATA_W  from SRAM controller
- mem_ready  in  1  from SRAM controller (high when its enable is high and the access is complete)
- grant  out  2  one-hot owner of the memory: 01 = p0, 10 = p1, 00 = none
- busy  out  1  high in GRANT0 or GRANT1

Behaviour:
- Request rules:
  - reqN = pN_read_en | pN_write_en.
  - The requester holds its strobes, address and write data stable until pN_ready is high.
  - If both strobes are high, the write wins; mem_read_en is forced to 0.
- FSM states: IDLE, GRANT0, GRANT1, RELEASE.
- IDLE:
  - No memory enables are driven.
  - If any reqN is high, register the winner and go to GRANT0 or GRANT1 on the next edge.
  - Fixed priority: p0 beats p1.
- GRANTx:
  - mem_* is a combinational pass-through of port x's strobes, address and write data; the selection itself is registered.
  - Completion: mem_ready & (mem_read_en | mem_write_en) gives a one-cycle px_ready pulse in that same cycle, then go to RELEASE.
  - Abort: if port x drops reqx before completion, go to RELEASE with no data capture.
- RELEASE:
  - Exactly one cycle with all mem enables low, so the controller's beat counter returns to 0.
  - Then go to IDLE, which re-arbitrates on the following cycle.
- Ready outputs: pN_ready = ~reqN | doneN. doneN is high only in the completion cycle of port N, so a port that is still requesting in RELEASE or IDLE sees ready = 0.
- Read data:
  - In the completion cycle of a read, pN_read_data = mem_read_data (bypass), and the value is captured into a per-port register.
  - Otherwise pN_read_data = the register, held until the next completed read of that port.
  - Writes do not change the register.
- Latency: 1 cycle (arbitration) + controller latency + 1 cycle (RELEASE) per transaction. Back-to-back requests from one port are therefore separated by at least 2 idle cycles on the mem enables.
- Simultaneous events:
  - A new request from the non-owner during GRANTx waits; it is arbitrated in IDLE after RELEASE.
  - If both ports request in IDLE, the priority rule decides.
- Reset (asserted at any time, including mid-transaction):
  - State = IDLE, grant = 00, busy = 0.
  - mem_read_en = mem_write_en = 0 immediately; mem_address = 0, mem_write_data = 0.
  - Both read_data registers = 0.
  - pN_ready follows ~reqN (no done pulse).
  - Round-robin pointer (when the optional feature is compiled in) = p0 preferred.
- grant equals the registered owner in GRANTx and is 00 in IDLE and RELEASE.

Optional Feature:
- Macro: SRAM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-served pointer, updated on each completion, selects the preferred port when both request in IDLE.
  - The port just served loses a tie. Reset value: p0 preferred.
  - Aborted transactions do not update the pointer.
- Undefined: strict fixed priority, p0 always wins ties. No pointer register exists.

Test Plan:
- Reset then idle: rst = 0 → 1, no requests → grant = 00, busy = 0, p0_ready = p1_ready = 1, mem enables 0, read data 0.
- Single write:
  - Stimulus: p0_write_en = 1, address 0x400, data 0xDEADBEEF; controller model with ready after 5 cycles.
  - Required: grant = 01 one cycle later; mem_address = 0x400, mem_write_data = 0xDEADBEEF; p0_ready pulses once; one RELEASE cycle with enables 0.
- Read after write:
  - Stimulus: p1_read_en = 1 at 0x400; model returns 0xDEADBEEF.
  - Required: p1_read_data = 0xDEADBEEF in the done cycle and held afterwards; p0_read_data unchanged.
- Tie: p0 and p1 request simultaneously, both held.
  - Fixed priority: p0 then p1.
  - SRAM_ARB_ROUND_ROBIN_EN: p0, p1, p0, p1 across repeated ties.
- Abort and reset:
  - Stimulus: p1 drops read_en mid-GRANT1; separately, rst = 0 mid-GRANT0.
  - Required on abort: RELEASE with no data capture and no ready pulse.
  - Required on reset: mem enables 0 immediately, state IDLE, grant = 00.
